dm_responder: RTL and testbench

- Data-memory responder on the far end of the control FSM's DM_Read/DM_Wr interface. It is the data-side counterpart to instruction fetch.
- Accepts one word read or write at a time, inserts a programmable number of wait states, then completes with a one-cycle DM_Ready pulse.
- Lets the multicycle control unit hold in its memory state until the access completes.
- 16-bit words, word-addressed.

---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_array.sv | 38 +++
 rtl/dm_responder.sv | 128 ++++++++++++
 tb/tb_dm_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared widths and encodings for the data-memory responder.
package dm_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/dm_array.sv
// DEPTH x DATA_W synchronous single-port storage with a registered read port.
// Contents are not reset; only the read register is.
module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              rd_zero,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register: updates only on a read, otherwise holds the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rd_zero ? '0 : mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word access at a time, inserts
// WAIT_CYCLES wait states, then completes with a one-cycle DM_Ready pulse.
// Optional macro DM_RANGE_CHECK_EN adds DM_Err and suppresses accesses at or
// above DEPTH instead of aliasing them.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DM_Read,
  input  logic              DM_Wr,
  input  logic [ADDR_W-1:0] DM_Addr,
  input  logic [DATA_W-1:0] DM_WData,
  output logic [DATA_W-1:0] DM_RData,
  output logic              DM_Ready,
`ifdef DM_RANGE_CHECK_EN
  output logic              DM_Err,
`endif
  output logic              DM_Busy
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic              ready_q, busy_q;
  logic              accept, oor_acc;
  logic              mem_we, mem_re;
  logic              unused_addr;

  assign unused_addr = ^DM_Addr;

  // Next-state logic; array read is issued on the edge entering DONE so the
  // data is already registered while DM_Ready is high.
  always_comb begin
    accept  = (state_q == IDLE) && (DM_Read || DM_Wr);
`ifdef DM_RANGE_CHECK_EN
    oor_acc = {16'd0, DM_Addr} >= 32'(DEPTH);
`else
    oor_acc = 1'b0;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = DM_Wr ? OP_WR : OP_RD;
          addr_d  = DM_Addr[AW-1:0];
          wdata_d = DM_WData;
          oor_d   = oor_acc;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_re = (state_d == DONE) && (op_d == OP_RD);
    mem_we = (state_q == DONE) && (op_q == OP_WR) && !oor_q;
  end

  // FSM state, latched access and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      ready_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef DM_RANGE_CHECK_EN
  logic err_q;

  // Error flag pulses alongside DM_Ready for an out-of-range access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_d == DONE) && oor_d;
  end

  assign DM_Err = err_q;
`endif

  dm_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we),
    .re     (mem_re),
    .rd_zero(oor_d),
    .addr   (addr_d),
    .wdata  (wdata_q),
    .rdata  (DM_RData)
  );

  assign DM_Ready = ready_q;
  assign DM_Busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: one instance with WAIT_CYCLES=2 (index 0) and one
// with WAIT_CYCLES=0 (index 1), driven from a vector table with a scoreboard.
module tb_dm_responder;

`ifdef DM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    int          dut;
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic        toggle;
  } vec_t;

  typedef struct {
    int          dut;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd  [2];
  logic        wr  [2];
  logic [15:0] ad  [2];
  logic [15:0] wd  [2];
  logic [15:0] rdat[2];
  logic        rdy [2];
  logic        bsy [2];
  logic        err [2];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .DM_Read(rd[0]), .DM_Wr(wr[0]),
    .DM_Addr(ad[0]), .DM_WData(wd[0]), .DM_RData(rdat[0]),
    .DM_Ready(rdy[0]),
`ifdef DM_RANGE_CHECK_EN
    .DM_Err(err[0]),
`endif
    .DM_Busy(bsy[0])
  );

  dm_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .DM_Read(rd[1]), .DM_Wr(wr[1]),
    .DM_Addr(ad[1]), .DM_WData(wd[1]), .DM_RData(rdat[1]),
    .DM_Ready(rdy[1]),
`ifdef DM_RANGE_CHECK_EN
    .DM_Err(err[1]),
`endif
    .DM_Busy(bsy[1])
  );

`ifndef DM_RANGE_CHECK_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input bit w, input bit r,
                              input logic [15:0] a, input logic [15:0] dta,
                              input logic [15:0] er, input bit ee, input bit tg);
    vec_t v;
    v.dut = dut; v.wr = w; v.rd = r; v.addr = a; v.data = dta;
    v.exp_rdata = er; v.exp_err = ee; v.toggle = tg;
    return v;
  endfunction

  // Drive one access, wait (bounded) for DM_Ready, compare against the scoreboard.
  task automatic run_access(input int idx, input vec_t v);
    int   d;
    int   lat;
    int   nb;
    bit   got;
    exp_t e;
    d = v.dut;
    @(negedge clk);
    rd[d] = v.rd; wr[d] = v.wr; ad[d] = v.addr; wd[d] = v.data;
    e.dut = d; e.exp_rdata = v.exp_rdata; e.exp_err = v.exp_err;
    e.exp_lat = (d == 0) ? 3 : 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    lat = 0; nb = 0; got = 1'b0;
    while (!got && lat < 40) begin
      if (v.toggle) begin
        wr[d] = 1'($urandom_range(0, 1));
        ad[d] = 16'($urandom);
        wd[d] = 16'($urandom);
      end
      @(negedge clk);
      lat++;
      if (bsy[d]) nb++;
      if (rdy[d]) got = 1'b1;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk($sformatf("v%0d_timeout", idx), 32'(lat), 32'(e.exp_lat));
    end else begin
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.exp_lat));
      chk($sformatf("v%0d_busy_cycles", idx), 32'(nb), 32'(e.exp_lat));
      chk($sformatf("v%0d_rdata", idx), 32'(rdat[e.dut]), 32'(e.exp_rdata));
      chk($sformatf("v%0d_err", idx), 32'(err[e.dut]), 32'(e.exp_err));
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_pulse", idx), 32'(rdy[d]), 32'd0);
    chk($sformatf("v%0d_busy_drop", idx), 32'(bsy[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_rdata%0d", i), 32'(rdat[i]), 32'd0);
      chk($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("reset_busy%0d", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("reset_err%0d", i), 32'(err[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Preload addr 5 with zero, then abort a write of BEEF with reset mid-WAIT.
    run_access(100, mk(0, 1, 0, 16'd5, 16'h0000, 16'h0000, 1'b0, 1'b0));
    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 16'd5; wd[0] = 16'hBEEF;
    @(posedge clk);
    #1;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_before_reset", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready_in_reset", 32'(rdy[0]), 32'd0);
    chk("abort_busy_in_reset", 32'(bsy[0]), 32'd0);
    chk("abort_rdata_in_reset", 32'(rdat[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ready_c%0d", c), 32'(rdy[0]), 32'd0);
    end

    // Vector table: WAIT_CYCLES=2 instance.
    tbl.push_back(mk(0, 0, 1, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mk(0, 1, 0, 16'h0003, 16'h1234, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mk(0, 0, 1, 16'h0003, 16'h0000, 16'h1234, 1'b0, 1'b0));
    tbl.push_back(mk(0, 1, 1, 16'h0009, 16'hAAAA, 16'h1234, 1'b0, 1'b0));
    tbl.push_back(mk(0, 0, 1, 16'h0009, 16'h0000, 16'hAAAA, 1'b0, 1'b0));
    tbl.push_back(mk(0, 1, 0, 16'h0105, 16'h5555, 16'hAAAA, RC, 1'b0));
    tbl.push_back(mk(0, 0, 1, 16'h0005, 16'h0000, RC ? 16'h0000 : 16'h5555, 1'b0, 1'b0));
    tbl.push_back(mk(0, 0, 1, 16'h0103, 16'h0000, RC ? 16'h0000 : 16'h1234, RC, 1'b0));
    tbl.push_back(mk(0, 1, 0, 16'h0010, 16'h7777, RC ? 16'h0000 : 16'h1234, 1'b0, 1'b1));
    tbl.push_back(mk(0, 0, 1, 16'h0010, 16'h0000, 16'h7777, 1'b0, 1'b0));
    // WAIT_CYCLES=0 instance: alternating write/read, data = addr*0101.
    for (int a = 0; a < 8; a++) begin
      tbl.push_back(mk(1, 1, 0, 16'(a), 16'(a * 16'h0101),
                       (a == 0) ? 16'h0000 : 16'((a - 1) * 16'h0101), 1'b0, 1'b0));
      tbl.push_back(mk(1, 0, 1, 16'(a), 16'h0000, 16'(a * 16'h0101), 1'b0, 1'b0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      run_access(i, tbl[i]);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
